// File: rtl/npu_host_driver.sv
// npu_host_driver
// Host-side master for the NPU shared 32-bit bus. It forwards a host word
// stream (config, weights/biases, inputs) to the NPU with we. It then waits
// for npu_ready, reads N3 result words with oe, and returns them to the host.
//
// State table
//   state  | meaning
//   IDLE   | waiting for start
//   CFG    | forwarding 5 config words (L, C0..C3)
//   WGT    | forwarding W weight/bias words
//   INP    | forwarding N0 input words
//   WAIT   | waiting for npu_ready, timeout running
//   READ   | issuing oe, one result per cycle
//   FIN    | one-cycle done pulse
//
// Ports
//   i_clk, i_rst (async, active-low)
//   i_start                      run request, accepted only in IDLE
//   i_src_data/i_src_valid       host word stream, o_src_ready = consumed
//   o_we, o_bus_out, o_bus_drive NPU write side (bus_drive == we)
//   o_oe, i_bus_in, i_npu_ready  NPU read side
//   o_res_data/o_res_valid       results to host, no backpressure
//   o_busy, o_done, o_error      status (error is sticky until next start)
module npu_host_driver #(
  parameter logic [19:0] TIMEOUT = 20'd1000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [31:0] i_src_data,
  input  logic        i_src_valid,
  output logic        o_src_ready,
  output logic        o_we,
  output logic        o_oe,
  output logic [31:0] o_bus_out,
  output logic        o_bus_drive,
  input  logic [31:0] i_bus_in,
  input  logic        i_npu_ready,
  output logic [31:0] o_res_data,
  output logic        o_res_valid,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error
);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_WGT, S_INP, S_WAIT, S_READ, S_FIN
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_layers;
  logic [3:0][4:0] r_code;
  logic [11:0]     r_cnt;
  logic [19:0]     r_tmo;
  logic [5:0]      r_rd_cnt;
  logic [31:0]     r_res_data;
  logic            r_res_valid;
  logic            r_error;

  logic [11:0] w_n0, w_n1, w_n2, w_n3;
  logic [11:0] w_wgt_total;
  logic [11:0] w_last_idx;
  logic [5:0]  w_n3_rd;
  logic [1:0]  w_cfg_idx;
  logic        w_fwd, w_xfer, w_last, w_rd_pending, w_oe, w_set_err;

  assign w_n0    = {7'd0, r_code[0]} + 12'd1;
  assign w_n1    = {7'd0, r_code[1]} + 12'd1;
  assign w_n2    = {7'd0, r_code[2]} + 12'd1;
  assign w_n3    = {7'd0, r_code[3]} + 12'd1;
  assign w_n3_rd = {1'b0, r_code[3]} + 6'd1;

  // Each layer contributes Nout*(Nin+1) words (weights plus bias).
  always_comb begin
    case (r_layers)
      2'd0:    w_wgt_total = w_n3 * (w_n0 + 12'd1);
      2'd1:    w_wgt_total = w_n1 * (w_n0 + 12'd1) + w_n3 * (w_n1 + 12'd1);
      default: w_wgt_total = w_n1 * (w_n0 + 12'd1) + w_n2 * (w_n1 + 12'd1)
                           + w_n3 * (w_n2 + 12'd1);
    endcase
  end

  assign w_rd_pending = (r_rd_cnt != w_n3_rd);
  assign w_xfer       = w_fwd & i_src_valid;
  assign w_last       = (r_cnt == w_last_idx);
  // Config word k (1..4) lands in code slot k-1; slot 3 comes from k=4 wrapping.
  assign w_cfg_idx    = r_cnt[1:0] - 2'd1;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fwd       = 1'b0;
    w_last_idx  = 12'd0;
    w_oe        = 1'b0;
    w_set_err   = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) w_state_nxt = S_CFG;
      S_CFG: begin
        w_fwd      = 1'b1;
        w_last_idx = 12'd4;
        // L was registered with word0, so it is stable by the last config word.
        if (i_src_valid && r_cnt == 12'd4) begin
          if (r_layers == 2'd3) begin
            w_set_err   = 1'b1;
            w_state_nxt = S_FIN;
          end else begin
            w_state_nxt = S_WGT;
          end
        end
      end
      S_WGT: begin
        w_fwd      = 1'b1;
        w_last_idx = w_wgt_total - 12'd1;
        if (i_src_valid && r_cnt == w_last_idx) w_state_nxt = S_INP;
      end
      S_INP: begin
        w_fwd      = 1'b1;
        w_last_idx = {7'd0, r_code[0]};
        if (i_src_valid && r_cnt == w_last_idx) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (i_npu_ready) begin
          w_state_nxt = S_READ;
        end else if (r_tmo == 20'd0) begin
          w_set_err   = 1'b1;
          w_state_nxt = S_FIN;
        end
      end
      S_READ: begin
        // The cycle after the last oe carries the last res_valid; done follows.
        if (!w_rd_pending) begin
          w_state_nxt = S_FIN;
        end else if (i_npu_ready) begin
          w_oe = 1'b1;
        end else begin
          w_set_err   = 1'b1;
          w_state_nxt = S_FIN;
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_layers    <= 2'd0;
      r_code      <= '0;
      r_cnt       <= 12'd0;
      r_tmo       <= 20'd0;
      r_rd_cnt    <= 6'd0;
      r_res_data  <= 32'd0;
      r_res_valid <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_res_valid <= w_oe;
      if (w_oe) r_res_data <= i_bus_in;
      if (r_state == S_IDLE && i_start) begin
        r_error  <= 1'b0;
        r_cnt    <= 12'd0;
        r_tmo    <= 20'd0;
        r_rd_cnt <= 6'd0;
      end else begin
        if (w_set_err) r_error <= 1'b1;
        if (w_xfer) begin
          r_cnt <= w_last ? 12'd0 : r_cnt + 12'd1;
          if (r_state == S_CFG) begin
            if (r_cnt == 12'd0) r_layers <= i_src_data[1:0];
            else                r_code[w_cfg_idx] <= i_src_data[4:0];
          end
          if (r_state == S_INP && w_last) r_tmo <= TIMEOUT - 20'd1;
        end
        if (r_state == S_WAIT && r_tmo != 20'd0) r_tmo <= r_tmo - 20'd1;
        if (w_oe) r_rd_cnt <= r_rd_cnt + 6'd1;
      end
    end
  end

  assign o_we        = w_xfer;
  assign o_src_ready = w_xfer;
  assign o_bus_drive = w_xfer;
  assign o_bus_out   = w_xfer ? i_src_data : 32'd0;
  assign o_oe        = w_oe;
  assign o_res_data  = r_res_data;
  assign o_res_valid = r_res_valid;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_FIN);
  assign o_error     = r_error;

endmodule

// File: tb/tb_npu_host_driver.sv
module tb_npu_host_driver;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_data = 32'd0;
  logic        src_valid = 1'b0;
  logic        src_ready, we, oe, bus_drive, res_valid, busy, done, error;
  logic [31:0] bus_out, res_data;
  logic [31:0] bus_in = 32'd0;
  logic        npu_ready = 1'b0;

  npu_host_driver #(.TIMEOUT(20'(TMO))) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_src_data(src_data), .i_src_valid(src_valid), .o_src_ready(src_ready),
    .o_we(we), .o_oe(oe), .o_bus_out(bus_out), .o_bus_drive(bus_drive),
    .i_bus_in(bus_in), .i_npu_ready(npu_ready),
    .o_res_data(res_data), .o_res_valid(res_valid),
    .o_busy(busy), .o_done(done), .o_error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] exp_bus_q[$];
  logic [31:0] exp_res_q[$];

  task automatic chk_eq(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops scoreboard queues whenever the DUT presents a word.
  int tot_wr = 0, tot_rd = 0, tot_done = 0, tot_we_rise = 0, tot_oe_rise = 0;
  int we_rise = 0, last_we = 0, oe_rise = 0, last_oe = 0, last_rv = 0, done_cyc = 0;
  bit done_err = 0, prev_oe = 0, prev_we = 0;

  always @(negedge clk) begin
    if (rst) begin
      chk_eq("bus_drive_eq_we", bus_drive, we);
      chk_eq("src_ready_eq_we", src_ready, we);
      chk_eq("res_valid_lags_oe", res_valid, prev_oe);
      if (we) begin
        if (!prev_we) begin we_rise = cyc; tot_we_rise++; end
        last_we = cyc;
        tot_wr++;
        chk_eq("write_expected", exp_bus_q.size() > 0, 1);
        if (exp_bus_q.size() > 0) chk_eq("bus_word", bus_out, exp_bus_q.pop_front());
      end
      if (oe) begin
        if (!prev_oe) begin oe_rise = cyc; tot_oe_rise++; end
        last_oe = cyc;
        tot_rd++;
      end
      if (res_valid) begin
        last_rv = cyc;
        chk_eq("result_expected", exp_res_q.size() > 0, 1);
        if (exp_res_q.size() > 0) chk_eq("res_data", res_data, exp_res_q.pop_front());
      end
      if (done) begin
        tot_done++;
        done_cyc = cyc;
        done_err = error;
        chk_eq("busy_at_done", busy, 1);
      end
      prev_oe = oe;
      prev_we = we;
    end else begin
      prev_oe = 0;
      prev_we = 0;
    end
  end

  task automatic chk_all_zero(input string name);
    chk_eq({name, "_ctl"}, {src_ready, we, oe, res_valid, done, error, busy, bus_drive}, 0);
    chk_eq({name, "_bus_out"}, bus_out, 0);
    chk_eq({name, "_res_data"}, res_data, 0);
  endtask

  // gap: 0 none, 1 toggle, 2 random. rmode: 0 normal, 1 never ready, 2 drop ready.
  // vmode: 0 random results, 1 index, 2 constant 1.0f.
  task automatic run(input int l, input int c0, input int c1, input int c2, input int c3,
                     input int gap, input int rmode, input int drop_after, input int vmode,
                     input bit hold_start, input int abort_at);
    int c[4];
    int n0, n1, n2, n3, w, exp_wr, exp_rd, wr, rd;
    int wr0, rd0, done0, wer0, oer0, start_cyc, ready_cyc, rdy_dly;
    bit exp_err, got_done, aborted, gate;
    logic [31:0] src[$];
    logic [31:0] vals[$];
    logic [31:0] v;
    c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
    n0 = c0 + 1; n1 = c1 + 1; n2 = c2 + 1; n3 = c3 + 1;
    case (l)
      0: w = n3 * (n0 + 1);
      1: w = n1 * (n0 + 1) + n3 * (n1 + 1);
      2: w = n1 * (n0 + 1) + n2 * (n1 + 1) + n3 * (n2 + 1);
      default: w = 0;
    endcase
    exp_wr  = (l == 3) ? 5 : 5 + w + n0;
    exp_err = (l == 3) || (rmode != 0);
    exp_rd  = (l == 3 || rmode == 1) ? 0 : (rmode == 2) ? drop_after : n3;

    v = ($urandom() & 32'hFFFF_FFFC) | 32'(l);
    src.push_back(v); exp_bus_q.push_back(v);
    for (int k = 0; k < 4; k++) begin
      v = ($urandom() & 32'hFFFF_FFE0) | 32'(c[k]);
      src.push_back(v); exp_bus_q.push_back(v);
    end
    if (l != 3) begin
      for (int i = 0; i < w + n0; i++) begin
        v = $urandom();
        src.push_back(v); exp_bus_q.push_back(v);
      end
    end else begin
      for (int i = 0; i < 4; i++) src.push_back($urandom());
    end
    for (int i = 0; i < n3; i++) begin
      v = (vmode == 0) ? $urandom() : (vmode == 1) ? 32'(i) : 32'h3F80_0000;
      vals.push_back(v);
      if (i < exp_rd) exp_res_q.push_back(v);
    end

    wr0 = tot_wr; rd0 = tot_rd; done0 = tot_done; wer0 = tot_we_rise; oer0 = tot_oe_rise;
    ready_cyc = -1; rdy_dly = $urandom_range(0, 3);
    got_done = 0; aborted = 0;

    @(posedge clk); #1;
    start = 1'b1;
    start_cyc = cyc;
    src_valid = 1'b1; src_data = src[0];
    bus_in = vals[0];

    for (int t = 0; t < 20000; t++) begin
      @(posedge clk); #1;
      if (tot_done != done0) begin got_done = 1; break; end
      wr = tot_wr - wr0;
      rd = tot_rd - rd0;
      start = hold_start && (wr == exp_wr);
      if (abort_at > 0 && wr >= abort_at) begin
        #2 rst = 1'b0;
        #1 chk_all_zero("reset_mid_run");
        exp_bus_q.delete(); exp_res_q.delete();
        src_valid = 1'b0; npu_ready = 1'b0; start = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        aborted = 1;
        break;
      end
      case (gap)
        0: gate = 1'b1;
        1: gate = (cyc % 2) == 1;
        default: gate = 1'($urandom_range(0, 1));
      endcase
      src_valid = (wr < src.size()) && gate;
      src_data  = (wr < src.size()) ? src[wr] : $urandom();
      bus_in    = (rd < vals.size()) ? vals[rd] : 32'hDEAD_BEEF;
      if (l != 3 && rmode != 1 && ready_cyc < 0 && wr == exp_wr) begin
        if (rdy_dly == 0) begin npu_ready = 1'b1; ready_cyc = cyc; end
        else rdy_dly--;
      end
      if (rmode == 2 && rd >= drop_after) npu_ready = 1'b0;
      if (cyc == start_cyc + 1) begin
        #2;
        chk_eq("error_cleared_by_start", error, 0);
        chk_eq("busy_after_start", busy, 1);
      end
    end
    start = 1'b0; npu_ready = 1'b0; src_valid = 1'b0;

    if (!aborted) begin
      chk_eq("done_within_budget", got_done, 1);
      chk_eq("write_count", tot_wr - wr0, exp_wr);
      chk_eq("read_count", tot_rd - rd0, exp_rd);
      chk_eq("error_at_done", done_err, exp_err);
      chk_eq("bus_queue_drained", exp_bus_q.size(), 0);
      chk_eq("result_queue_drained", exp_res_q.size(), 0);
      if (gap == 0) begin
        chk_eq("first_we_after_start", we_rise, start_cyc + 1);
        chk_eq("we_contiguous", tot_we_rise - wer0, 1);
        chk_eq("we_span", last_we - we_rise + 1, exp_wr);
      end
      if (gap == 1) chk_eq("we_follows_toggle", tot_we_rise - wer0, exp_wr);
      if (l == 3) chk_eq("done_after_cfg", done_cyc, last_we + 1);
      else if (rmode == 1) chk_eq("timeout_done", done_cyc, last_we + TMO + 1);
      else begin
        chk_eq("first_oe_after_ready", oe_rise, ready_cyc + 1);
        chk_eq("oe_contiguous", tot_oe_rise - oer0, 1);
        if (rmode == 0) chk_eq("done_after_last_result", done_cyc, last_rv + 1);
        else            chk_eq("done_after_drop", done_cyc, last_oe + 2);
      end
      @(negedge clk);
      @(negedge clk);
      chk_eq("idle_after_done", busy, 0);
      chk_eq("error_sticky", error, exp_err);
      exp_bus_q.delete(); exp_res_q.delete();
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int l, c0, c1, c2, c3, g, rm, dr;
    #2 chk_all_zero("reset_state");
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);

    run(0, 1, $urandom_range(0, 31), $urandom_range(0, 31), 0, 0, 0, 0, 2, 0, 0);
    run(2, 31, 31, 31, 31, 0, 0, 0, 1, 0, 0);
    run(3, 4, 5, 6, 7, 0, 0, 0, 0, 1, 0);
    run(0, 2, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    run(1, 3, 2, $urandom_range(0, 31), 1, 1, 0, 0, 0, 0, 0);
    run(2, 5, 6, 7, 3, 0, 0, 0, 0, 0, 40);
    run(1, 2, 3, 0, 2, 0, 0, 0, 0, 1, 0);

    for (int i = 0; i < 6; i++) begin
      l  = $urandom_range(0, 2);
      c0 = $urandom_range(0, 7); c1 = $urandom_range(0, 7);
      c2 = $urandom_range(0, 7); c3 = $urandom_range(0, 7);
      g  = $urandom_range(0, 2);
      rm = (c3 > 0 && $urandom_range(0, 1) == 1) ? 2 : 0;
      dr = (rm == 2) ? $urandom_range(1, c3) : 0;
      run(l, c0, c1, c2, c3, g, rm, dr, 0, 1'($urandom_range(0, 1)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/npu_host_driver.md
# npu_host_driver

Host-side master for the NPU's shared 32-bit data bus. It takes a word stream from the host (configuration, weights/biases, input vector) and drives it onto the NPU bus with `we`. It then waits for the NPU `ready` flag, reads each output neuron with `oe`, and returns the results to the host. It sits between the host FIFO/DMA and the `npu` instance; the top level builds the tristate from `bus_out`/`bus_drive`.

## Interface
- `TIMEOUT`, 20'd1000000: cycles to wait for `npu_ready` before flagging an error.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request to run one inference; ignored unless idle.
- `src_data`  in  32  host word stream.
- `src_valid`  in  1  `src_data` is valid.
- `src_ready`  out  1  word consumed this cycle.
- `we`  out  1  NPU write enable; the NPU consumes one word per cycle with `we`=1.
- `oe`  out  1  NPU output enable; requests one output word.
- `bus_out`  out  32  word driven to the NPU bus.
- `bus_drive`  out  1  tristate enable for `bus_out`; always equals `we`.
- `bus_in`  in  32  NPU bus read value.
- `npu_ready`  in  1  NPU is in its output-send phase.
- `res_data`  out  32  result word.
- `res_valid`  out  1  `res_data` is valid. There is no backpressure; the host must accept it.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse at the end of a run.
- `error`  out  1  sticky error; cleared by the next accepted `start`.

## Operation
- States: IDLE, CFG, WGT, INP, WAIT, READ, FIN.
- IDLE: on `start`=1, go to CFG, clear `error`, clear counters.
- CFG: forward 5 words. Word0 gives L = bits[1:0]. Words 1–4 give neuron codes C0..C3 from bits[4:0]; layer size Nk = Ck+1 (range 1..32).
  - If L = 3, finish the CFG phase, then set `error` and go to FIN without sending weights.
- Each forwarded word is registered into its config field on the same edge it is sent.
- Weight count W:
  - L=0: N3·(N0+1).
  - L=1: N1·(N0+1) + N3·(N1+1).
  - L=2: N1·(N0+1) + N2·(N1+1) + N3·(N2+1).
  - W is computed from the registered fields; maximum 3168, so use a 12-bit counter.
- WGT: forward W words, then go to INP.
- INP: forward N0 words, then go to WAIT.
- Forwarding rule for CFG/WGT/INP:
  - `we` = `src_ready` = `src_valid` while in the state.
  - `bus_out` = `src_data` (combinational, registered NPU side).
  - When `src_valid`=0, hold `we`=0; the stream pauses with no word lost or repeated.
- WAIT: `we`=0 and a timeout counter runs.
  - When `npu_ready`=1, go to READ.
  - If the counter reaches `TIMEOUT` first, set `error` and go to FIN.
- READ: assert `oe` for exactly N3 consecutive cycles, then deassert.
  - Each `bus_in` word is captured into `res_data` with `res_valid` 1 cycle after its `oe` cycle.
  - After the last result, go to FIN.
  - If `npu_ready` drops before N3 reads, set `error` and stop asserting `oe`; results already captured stand.
- FIN: pulse `done` for one cycle, go to IDLE.
- `busy` = 1 in every state except IDLE.

## Timing
- Reset: all outputs 0 (`bus_out`=0, `src_ready`=0, `we`=0, `oe`=0, `res_valid`=0, `done`=0, `error`=0, `busy`=0); state IDLE; all counters 0.
- Reset mid-run aborts immediately. The next run starts only from a new `start`.
- `start` → first possible `we`: 1 cycle (CFG entered on the edge after `start`).
- CFG→WGT, WGT→INP and INP→WAIT transitions occur on the edge of the last word's transfer, with no bubble. With an ungapped source, total write cycles = 5 + W + N0.
- `npu_ready`=1 in WAIT → first `oe` on the next cycle.
- `oe` cycles are contiguous; `res_valid` is contiguous and lags `oe` by 1.
- `done` comes 1 cycle after the last `res_valid`, or after the error detection.
- `start` while `busy`=1 is ignored; `start` coincident with `done` is also ignored.

## Test plan
- L=0, C0=1, C3=0 (2 inputs, 1 output), gap-free source → `we` high for 10 consecutive cycles (5 config + 3 weights + 2 inputs). After `npu_ready`, 1 `oe` cycle; `res_data`=`bus_in` value 0x3F800000 one cycle later; then `done`.
- L=2, all Ck=31 → W=3168; `we` count = 3205. Then 32 `oe` cycles and 32 `res_valid` pulses carrying 0..31 from a bus model, in order.
- L=1, C0=3, C1=2, C3=1, `src_valid` toggling 1/0 → `we` mirrors `src_valid`. The NPU model receives exactly 5+15+8+4=32 words, in order, without duplicates.
- Word0=3 → after 5 config words, `error`=1, `done` pulses, no further `we`.
- `TIMEOUT`=16, `npu_ready` never asserted → `error` and `done` 16 cycles after WAIT entry. The next `start` clears `error`.
- Reset asserted mid-WGT → all outputs 0 immediately. A new run after release behaves as a clean run.
